// File: rtl/vc_flit_requester.sv
// Per-VC input buffering and request generation for the two-way router arbiter.
// Forwards granted packets through a registered output stage and holds the packet lock from head to tail.
module vc_flit_requester #(
  parameter int FLIT_W = 34,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        in_valid_i,
  input  logic [FLIT_W-1:0] in_flit_i,
  output logic [1:0]        in_ready_o,
  output logic [1:0]        req_o,
  input  logic [1:0]        grant_i,
  output logic              out_valid_o,
  output logic [FLIT_W-1:0] out_flit_o,
  output logic              out_vc_o,
  input  logic              out_ready_i,
  output logic              err_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                  state_q;
  logic                    lock_vc_q;
  logic                    out_valid_q;
  logic [FLIT_W-1:0]       out_flit_q;
  logic                    out_vc_q;
  logic                    err_q;

  logic [1:0]              empty, full, is_head, is_bad, push, pop, disc, sel, g;
  logic [1:0][FLIT_W-1:0]  head_flit;
  logic                    ld, lock_pop, load;
  logic                    out_vc_d;
  logic [FLIT_W-1:0]       out_flit_d;
  logic [1:0]              load_type;

  // Each VC owns a circular buffer; a count of DEPTH means full.
  for (genvar v = 0; v < 2; v++) begin : g_fifo
    logic [FLIT_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PW:0]       cnt_q;

    assign empty[v]     = (cnt_q == '0);
    assign full[v]      = (cnt_q == (PW+1)'(DEPTH));
    assign head_flit[v] = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
      if (push[v]) mem_q[wr_ptr_q] <= in_flit_i;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        if (push[v]) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop[v])  rd_ptr_q <= rd_ptr_q + 1'b1;
        case ({push[v], pop[v]})
          2'b10:   cnt_q <= cnt_q + 1'b1;
          2'b01:   cnt_q <= cnt_q - 1'b1;
          default: cnt_q <= cnt_q;
        endcase
      end
    end

    // Bit FLIT_W-2 set marks HEAD or HEAD_TAIL, the only legal packet starts.
    assign is_head[v] = ~empty[v] & head_flit[v][FLIT_W-2];
    assign is_bad[v]  = ~empty[v] & ~head_flit[v][FLIT_W-2];
  end

  assign in_ready_o = {2{~rst}} & ~full;
  assign push[0]    = in_valid_i[0] & in_ready_o[0];
  assign push[1]    = in_valid_i[1] & in_ready_o[1] & ~push[0];

  assign ld    = ~out_valid_q | out_ready_i;
  assign req_o = {2{~rst & (state_q == IDLE) & ld}} & is_head;
  assign g     = grant_i & req_o;
  assign sel   = {g[1] & ~g[0], g[0]};
  assign disc  = (state_q == IDLE) ? {is_bad[1] & ~is_bad[0], is_bad[0]} : 2'b00;

  assign lock_pop = (state_q == LOCKED) & ld & ~empty[lock_vc_q];
  assign pop[0]   = sel[0] | disc[0] | (lock_pop & ~lock_vc_q);
  assign pop[1]   = sel[1] | disc[1] | (lock_pop & lock_vc_q);

  assign load       = (|sel) | lock_pop;
  assign out_vc_d   = lock_pop ? lock_vc_q : sel[1];
  assign out_flit_d = head_flit[out_vc_d];
  assign load_type  = out_flit_d[FLIT_W-1 -: 2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lock_vc_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_flit_q  <= '0;
      out_vc_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // Out-of-place starts inside a packet are forwarded but still flagged.
      err_q <= (|disc) | (lock_pop & load_type[0]);
      if (load) begin
        out_valid_q <= 1'b1;
        out_flit_q  <= out_flit_d;
        out_vc_q    <= out_vc_d;
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if ((|sel) && load_type == T_HEAD) begin
            state_q   <= LOCKED;
            lock_vc_q <= out_vc_d;
          end
        end
        LOCKED: begin
          if (lock_pop && load_type == T_TAIL) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_flit_o  = out_flit_q;
  assign out_vc_o    = out_vc_q;
  assign err_o       = err_q;
endmodule

// File: tb/tb_vc_flit_requester.sv
// Bench for vc_flit_requester: directed scenarios then random traffic, all checked cycle by cycle
// against a queue-based packet model of the requester.
module tb_vc_flit_requester;
  localparam int FW = 34;
  localparam int D  = 4;
  localparam logic [1:0] BODY = 2'b00, HEAD = 2'b01, TAIL = 2'b10, HT = 2'b11;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    in_valid_i;
  logic [FW-1:0] in_flit_i;
  logic [1:0]    in_ready_o;
  logic [1:0]    req_o;
  logic [1:0]    grant_i;
  logic          out_valid_o;
  logic [FW-1:0] out_flit_o;
  logic          out_vc_o;
  logic          out_ready_i;
  logic          err_o;

  always #5 clk = ~clk;

  vc_flit_requester #(.FLIT_W(FW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_i), .in_flit_i(in_flit_i), .in_ready_o(in_ready_o),
    .req_o(req_o), .grant_i(grant_i),
    .out_valid_o(out_valid_o), .out_flit_o(out_flit_o), .out_vc_o(out_vc_o),
    .out_ready_i(out_ready_i), .err_o(err_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one queue per VC plus the packet lock and the output register.
  logic [FW-1:0] mq0[$];
  logic [FW-1:0] mq1[$];
  bit            m_lock = 0;
  bit            m_lvc = 0;
  bit            m_ov = 0;
  logic [FW-1:0] m_of = '0;
  bit            m_ovc = 0;
  bit            m_err = 0;

  function automatic int qsz(bit v);
    return v ? mq1.size() : mq0.size();
  endfunction

  function automatic logic [FW-1:0] qfront(bit v);
    return v ? mq1[0] : mq0[0];
  endfunction

  function automatic logic [1:0] ftype(logic [FW-1:0] f);
    return f[FW-1:FW-2];
  endfunction

  function automatic bit starts_pkt(logic [FW-1:0] f);
    return ftype(f) == HEAD || ftype(f) == HT;
  endfunction

  task automatic qpop(bit v);
    if (v) void'(mq1.pop_front());
    else   void'(mq0.pop_front());
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_comb(input logic r, input logic ordy,
                            output logic [1:0] ereq, output logic [1:0] erdy);
    ereq = 2'b00;
    erdy = 2'b00;
    if (!r) begin
      for (int i = 0; i < 2; i++) begin
        bit vc;
        vc = bit'(i);
        erdy[vc] = qsz(vc) < D;
        if (!m_lock && (!m_ov || ordy) && qsz(vc) > 0 && starts_pkt(qfront(vc)))
          ereq[vc] = 1'b1;
      end
    end
  endtask

  task automatic model_update(input logic r, input logic [1:0] iv, input logic [FW-1:0] fl,
                              input logic [1:0] gr, input logic ordy,
                              input logic [1:0] ereq, input logic [1:0] erdy);
    bit ld, load, nerr, lv, bad0, bad1;
    logic [1:0] g;
    logic [FW-1:0] lf;
    if (r) begin
      mq0.delete(); mq1.delete();
      m_lock = 0; m_lvc = 0; m_ov = 0; m_of = '0; m_ovc = 0; m_err = 0;
      return;
    end
    ld = !m_ov || ordy; load = 0; nerr = 0; lv = 0; lf = '0;
    if (!m_lock) begin
      bad0 = qsz(1'b0) > 0 && !starts_pkt(qfront(1'b0));
      bad1 = qsz(1'b1) > 0 && !starts_pkt(qfront(1'b1));
      if (bad0) begin qpop(1'b0); nerr = 1; end
      else if (bad1) begin qpop(1'b1); nerr = 1; end
      g = gr & ereq;
      if (g != 2'b00) begin
        lv = !g[0];
        lf = qfront(lv);
        qpop(lv);
        load = 1;
        if (ftype(lf) == HEAD) begin m_lock = 1; m_lvc = lv; end
      end
    end else if (ld && qsz(m_lvc) > 0) begin
      lv = m_lvc;
      lf = qfront(lv);
      qpop(lv);
      load = 1;
      if (ftype(lf) == TAIL) m_lock = 0;
      else if (starts_pkt(lf)) nerr = 1;
    end
    if (load) begin m_ov = 1; m_of = lf; m_ovc = lv; end
    else if (ordy) m_ov = 0;
    m_err = nerr;
    if (iv[0] && erdy[0]) mq0.push_back(fl);
    else if (iv[1] && erdy[1]) mq1.push_back(fl);
  endtask

  // One clock cycle: drive at the falling edge, check requests, then check registers after the rising edge.
  task automatic step(input logic r, input logic [1:0] iv, input logic [FW-1:0] fl,
                      input logic [1:0] gr, input bit follow, input logic ordy);
    logic [1:0] ereq, erdy, gd;
    model_comb(r, ordy, ereq, erdy);
    gd = follow ? ereq : gr;
    rst = r; in_valid_i = iv; in_flit_i = fl; grant_i = gd; out_ready_i = ordy;
    #1;
    chk("req_o", req_o, ereq);
    chk("in_ready_o", in_ready_o, erdy);
    model_update(r, iv, fl, gd, ordy, ereq, erdy);
    @(posedge clk);
    #1;
    chk("out_valid_o", out_valid_o, m_ov);
    chk("out_vc_o", out_vc_o, m_ovc);
    chk("out_flit_o", out_flit_o, m_of);
    chk("err_o", err_o, m_err);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, '0, 2'b00, 1'b1, ordy);
  endtask

  function automatic logic [FW-1:0] mk(logic [1:0] t, logic [31:0] p);
    return {t, p};
  endfunction

  initial begin
    logic [FW-1:0] stall_flit;
    rst = 1'b1; in_valid_i = 2'b00; in_flit_i = '0; grant_i = 2'b00; out_ready_i = 1'b0;
    @(negedge clk);
    step(1'b1, 2'b00, '0, 2'b00, 1'b1, 1'b0);
    step(1'b1, 2'b00, '0, 2'b00, 1'b1, 1'b0);
    chk("reset_out_valid", out_valid_o, 1'b0);
    chk("reset_out_flit", out_flit_o, 34'h0);

    // Single HEAD_TAIL on VC0.
    step(1'b0, 2'b01, mk(HT, 32'h0000_00AA), 2'b00, 1'b1, 1'b1);
    step(1'b0, 2'b00, '0, 2'b00, 1'b1, 1'b1);
    chk("t1_valid", out_valid_o, 1'b1);
    chk("t1_flit", out_flit_o, 34'h3_0000_00AA);
    chk("t1_vc", out_vc_o, 1'b0);
    idle(2, 1'b1);

    // Packet on VC1 with a HEAD_TAIL queued on VC0 behind it.
    step(1'b0, 2'b10, mk(HEAD, 32'h11), 2'b00, 1'b0, 1'b1);
    step(1'b0, 2'b10, mk(BODY, 32'h12), 2'b10, 1'b0, 1'b1);
    step(1'b0, 2'b10, mk(TAIL, 32'h13), 2'b11, 1'b0, 1'b1);
    step(1'b0, 2'b01, mk(HT, 32'h20), 2'b11, 1'b0, 1'b1);
    idle(4, 1'b1);

    // Stall the output, fill VC0, then drain.
    step(1'b0, 2'b01, mk(HT, 32'h30), 2'b00, 1'b1, 1'b0);
    idle(1, 1'b0);
    stall_flit = out_flit_o;
    for (int i = 0; i < 4; i++) step(1'b0, 2'b01, mk(HT, 32'h31 + i), 2'b00, 1'b1, 1'b0);
    chk("t3_full", in_ready_o, 2'b10);
    step(1'b0, 2'b01, mk(HT, 32'h3F), 2'b00, 1'b1, 1'b0);
    chk("t3_hold", out_flit_o, stall_flit);
    idle(7, 1'b1);

    // Both VCs hold heads and both grant bits are driven.
    step(1'b0, 2'b01, mk(HT, 32'h40), 2'b00, 1'b0, 1'b1);
    step(1'b0, 2'b10, mk(HT, 32'h41), 2'b00, 1'b0, 1'b1);
    step(1'b0, 2'b00, '0, 2'b11, 1'b0, 1'b1);
    chk("t4_vc0_first", out_vc_o, 1'b0);
    idle(3, 1'b1);

    // Stray BODY on VC1 while idle.
    step(1'b0, 2'b10, mk(BODY, 32'h50), 2'b00, 1'b0, 1'b1);
    step(1'b0, 2'b00, '0, 2'b00, 1'b1, 1'b1);
    chk("t5_err_pulse", err_o, 1'b1);
    chk("t5_no_output", out_valid_o, 1'b0);
    step(1'b0, 2'b00, '0, 2'b00, 1'b1, 1'b1);
    chk("t5_err_clear", err_o, 1'b0);

    // Reset in the middle of a locked packet.
    step(1'b0, 2'b01, mk(HEAD, 32'h60), 2'b00, 1'b1, 1'b1);
    step(1'b0, 2'b01, mk(BODY, 32'h61), 2'b00, 1'b1, 1'b1);
    step(1'b0, 2'b01, mk(BODY, 32'h62), 2'b00, 1'b1, 1'b0);
    step(1'b1, 2'b00, '0, 2'b00, 1'b1, 1'b1);
    chk("t6_valid_cleared", out_valid_o, 1'b0);
    step(1'b0, 2'b01, mk(HT, 32'h63), 2'b00, 1'b1, 1'b1);
    idle(3, 1'b1);

    // Random traffic.
    for (int n = 0; n < 2000; n++) begin
      logic r, ordy;
      logic [1:0] iv, gr;
      bit follow;
      int s;
      r = ($urandom_range(0, 249) == 0);
      s = $urandom_range(0, 9);
      iv = (s < 4) ? 2'b01 : (s < 8) ? 2'b10 : (s == 8) ? 2'b11 : 2'b00;
      gr = 2'($urandom_range(0, 3));
      follow = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      step(r, iv, mk(2'($urandom_range(0, 3)), 32'($urandom)), gr, follow, ordy);
    end
    idle(12, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
